// File: rtl/modmul_pkg.sv
// Shared constants and helpers for the multi-lane Barrett modular multiplier.
package modmul_pkg;

  // round(2^k / q) for odd q
  function automatic longint barrett_m(input longint q, input int k);
    return ((longint'(1) <<< k) + (q / 2)) / q;
  endfunction

  function automatic int centre_bound(input int q);
    return (q - 1) / 2;
  endfunction

  function automatic int in_lsb(input int lane, input int w);
    return lane * w;
  endfunction

  function automatic int out_lsb(input int lane, input int w);
    return lane * (w + 1);
  endfunction

endpackage

// File: rtl/modmul_lane.sv
// One lane of the 4-stage signed Barrett multiplier; flow control lives in the top.
module modmul_lane
  import modmul_pkg::*;
#(
  parameter int Q = 15361,
  parameter int W = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                vld3_i,
  input  logic                lazy3_i,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W:0]   c_o
);

  localparam int K  = 2 * W;
  localparam int HB = centre_bound(Q);
  localparam logic signed [63:0]    M    = 64'(barrett_m(Q, K));
  localparam logic signed [63:0]    HALF = 64'(longint'(1) <<< (K - 1));
  localparam logic signed [W:0]     QS   = (W + 1)'(Q);
  localparam logic signed [W:0]     HBS  = (W + 1)'(HB);
  localparam logic signed [2*W-1:0] QZ   = (2 * W)'(Q);

  logic signed [2*W-1:0] z1_q, z2_q;
  logic signed [W:0]     qh2_q, r3_q, c4_q, c4_d;

  // Datapath stages carry don't-care data when invalid, so they need no reset.
  always_ff @(posedge clk) begin
    if (en_i) begin
      z1_q  <= (2 * W)'(a_i) * (2 * W)'(b_i);
      z2_q  <= z1_q;
      qh2_q <= (W + 1)'((64'(z1_q) * M + HALF) >>> K);
      r3_q  <= (W + 1)'(z2_q - (2 * W)'(qh2_q) * QZ);
    end
  end

  always_comb begin
    c4_d = r3_q;
    if (!lazy3_i) begin
      if (r3_q > HBS)       c4_d = r3_q - QS;
      else if (r3_q < -HBS) c4_d = r3_q + QS;
    end
    if (!vld3_i) c4_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)       c4_q <= '0;
    else if (en_i) c4_q <= c4_d;
  end

  assign c_o = c4_q;

endmodule

// File: rtl/modmul_q_pipe.sv
// Multi-lane signed modular multiplier, outC = inA*inB mod Q, 4-stage valid/ready pipeline.
module modmul_q_pipe
  import modmul_pkg::*;
#(
  parameter int Q     = 15361,
  parameter int W     = 14,
  parameter int LANES = 2,
  parameter int TAGW  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_lazy,
  input  logic [TAGW-1:0]          in_tag,
  input  logic [LANES*W-1:0]       inA,
  input  logic [LANES*W-1:0]       inB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAGW-1:0]          out_tag,
  output logic [LANES*(W+1)-1:0]   outC
);

  localparam int     K  = 2 * W;
  localparam longint HB = centre_bound(Q);

  if ((HB * HB >= (longint'(1) <<< (K - 2))) || ((Q % 2) == 0) ||
      (HB >= (longint'(1) <<< (W - 1)))) begin : g_param_check
    $error("modmul_q_pipe: unsupported Q/W combination");
  end

  logic                 en;
  logic [3:0]           vld_q, vld_d;
  logic [2:0]           lazy_q;
  logic [3:0][TAGW-1:0] tag_q;

  assign en       = !vld_q[3] || out_ready;
  assign in_ready = en;
  assign vld_d    = {vld_q[2:0], in_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      lazy_q <= '0;
      tag_q  <= '0;
    end else if (en) begin
      vld_q    <= vld_d;
      lazy_q   <= {lazy_q[1:0], in_lazy};
      tag_q[0] <= in_tag;
      tag_q[1] <= tag_q[0];
      tag_q[2] <= tag_q[1];
      tag_q[3] <= vld_q[2] ? tag_q[2] : '0;
    end
  end

  assign out_valid = vld_q[3];
  assign out_tag   = tag_q[3];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    modmul_lane #(
      .Q (Q),
      .W (W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en),
      .vld3_i  (vld_q[2]),
      .lazy3_i (lazy_q[2]),
      .a_i     (inA[in_lsb(i, W) +: W]),
      .b_i     (inB[in_lsb(i, W) +: W]),
      .c_o     (outC[out_lsb(i, W) +: W + 1])
    );
  end

endmodule
